// File: rtl/exc_ctrl.sv
// Commit-stage exception/interrupt/eret controller: prioritises causes, emits a
// one-cycle event strobe to CP0, then flushes and redirects fetch until accepted.
module exc_ctrl #(
    parameter logic [31:0] VEC_BEV  = 32'hBFC0_0380,
    parameter logic [31:0] VEC_NORM = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_valid,
    input  logic        m_stall,
    input  logic [31:0] m_pc,
    input  logic [31:0] m_addr,
    input  logic        m_bd,
    input  logic        m_if_adel,
    input  logic        m_ri,
    input  logic        m_sys,
    input  logic        m_bp,
    input  logic        m_ov,
    input  logic        m_ld_adel,
    input  logic        m_st_ades,
    input  logic        m_eret,
    input  logic        int_req,
    input  logic        bev,
    input  logic [31:0] cp0_epc,
    output logic        exc_valid,
    output logic        exc_bd,
    output logic        exc_eret,
    output logic [4:0]  exc_excode,
    output logic [31:0] exc_epc,
    output logic [31:0] exc_badvaddr,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready
);
    typedef enum logic [0:0] {IDLE, REDIRECT} state_t;

    // Bit 8 is the highest priority cause, bit 0 (eret) the lowest.
    localparam logic [4:0] CAUSE_CODE [0:8] = '{5'd0, 5'd5, 5'd4, 5'd12, 5'd9, 5'd8, 5'd10, 5'd4, 5'd0};

    state_t      state_reg, state_next;
    logic        exc_valid_reg, exc_bd_reg, exc_eret_reg;
    logic [4:0]  exc_excode_reg, exc_excode_next;
    logic [31:0] exc_epc_reg, exc_epc_next;
    logic [31:0] exc_badvaddr_reg, exc_badvaddr_next;
    logic [31:0] redirect_pc_reg, redirect_pc_next;

    logic [8:0]  cause_vec;
    logic [8:0]  win;
    logic [4:0]  code_term [0:8];
    logic        capture;

    assign cause_vec = {int_req, m_if_adel, m_ri, m_sys, m_bp, m_ov, m_ld_adel, m_st_ades, m_eret};
    assign capture   = (state_reg == IDLE) && m_valid && !m_stall && (|cause_vec);

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_prio
            assign win[gi]       = cause_vec[gi] && ((cause_vec >> (gi + 1)) == 9'd0);
            assign code_term[gi] = win[gi] ? CAUSE_CODE[gi] : 5'd0;
        end
    endgenerate

    always_comb begin
        exc_excode_next = 5'd0;
        for (int i = 0; i < 9; i++) begin
            exc_excode_next = exc_excode_next | code_term[i];
        end
        exc_epc_next      = m_bd ? (m_pc - 32'd4) : m_pc;
        exc_badvaddr_next = 32'd0;
        if (win[7]) begin
            exc_badvaddr_next = m_pc;
        end else if (win[2] || win[1]) begin
            exc_badvaddr_next = m_addr;
        end
        redirect_pc_next = win[0] ? cp0_epc : (bev ? VEC_BEV : VEC_NORM);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (capture) state_next = REDIRECT;
            REDIRECT: if (redirect_ready) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg        <= IDLE;
            exc_valid_reg    <= 1'b0;
            exc_bd_reg       <= 1'b0;
            exc_eret_reg     <= 1'b0;
            exc_excode_reg   <= 5'd0;
            exc_epc_reg      <= 32'd0;
            exc_badvaddr_reg <= 32'd0;
            redirect_pc_reg  <= 32'd0;
        end else begin
            state_reg     <= state_next;
            exc_valid_reg <= capture;
            if (capture) begin
                exc_bd_reg       <= m_bd;
                exc_eret_reg     <= win[0];
                exc_excode_reg   <= exc_excode_next;
                exc_epc_reg      <= exc_epc_next;
                exc_badvaddr_reg <= exc_badvaddr_next;
                redirect_pc_reg  <= redirect_pc_next;
            end
        end
    end

    assign exc_valid      = exc_valid_reg;
    assign exc_bd         = exc_bd_reg;
    assign exc_eret       = exc_eret_reg;
    assign exc_excode     = exc_excode_reg;
    assign exc_epc        = exc_epc_reg;
    assign exc_badvaddr   = exc_badvaddr_reg;
    assign flush          = (state_reg == REDIRECT);
    assign redirect_valid = (state_reg == REDIRECT);
    assign redirect_pc    = redirect_pc_reg;
endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: expected events are queued at issue time and a
// negedge monitor pops and compares them whenever exc_valid is seen.
module tb_exc_ctrl;
    logic        clk = 1'b0;
    logic        resetn;
    logic        m_valid, m_stall, m_bd;
    logic [31:0] m_pc, m_addr;
    logic        m_if_adel, m_ri, m_sys, m_bp, m_ov, m_ld_adel, m_st_ades, m_eret;
    logic        int_req, bev;
    logic [31:0] cp0_epc;
    logic        exc_valid, exc_bd, exc_eret;
    logic [4:0]  exc_excode;
    logic [31:0] exc_epc, exc_badvaddr;
    logic        flush, redirect_valid, redirect_ready;
    logic [31:0] redirect_pc;

    localparam logic [8:0] F_INT = 9'h100, F_IFADEL = 9'h080, F_RI = 9'h040, F_SYS = 9'h020,
                           F_BP = 9'h010, F_OV = 9'h008, F_LD = 9'h004, F_ST = 9'h002, F_ERET = 9'h001;

    typedef struct {
        logic [4:0]  code;
        logic        bd;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] bad;
        logic [31:0] rpc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   fcnt;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk(clk), .resetn(resetn),
        .m_valid(m_valid), .m_stall(m_stall), .m_pc(m_pc), .m_addr(m_addr), .m_bd(m_bd),
        .m_if_adel(m_if_adel), .m_ri(m_ri), .m_sys(m_sys), .m_bp(m_bp), .m_ov(m_ov),
        .m_ld_adel(m_ld_adel), .m_st_ades(m_st_ades), .m_eret(m_eret),
        .int_req(int_req), .bev(bev), .cp0_epc(cp0_epc),
        .exc_valid(exc_valid), .exc_bd(exc_bd), .exc_eret(exc_eret), .exc_excode(exc_excode),
        .exc_epc(exc_epc), .exc_badvaddr(exc_badvaddr), .flush(flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_m();
        m_valid = 0; m_stall = 0; m_bd = 0;
        {int_req, m_if_adel, m_ri, m_sys, m_bp, m_ov, m_ld_adel, m_st_ades, m_eret} = 9'd0;
    endtask

    // Present one capturing instruction for a single cycle and queue its expected event.
    task automatic issue(input logic [31:0] pc, input logic [31:0] addr, input logic bd,
                         input logic [8:0] f, input logic b, input logic [31:0] epc_in,
                         input logic [4:0] e_code, input logic e_bd, input logic e_eret,
                         input logic [31:0] e_epc, input logic [31:0] e_bad, input logic [31:0] e_rpc);
        exp_t e;
        e.code = e_code; e.bd = e_bd; e.eret = e_eret; e.epc = e_epc; e.bad = e_bad; e.rpc = e_rpc;
        sb.push_back(e);
        m_pc = pc; m_addr = addr; m_bd = bd; bev = b; cp0_epc = epc_in;
        {int_req, m_if_adel, m_ri, m_sys, m_bp, m_ov, m_ld_adel, m_st_ades, m_eret} = f;
        m_valid = 1; m_stall = 0;
        @(posedge clk); #1;
        clear_m();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!redirect_valid) return;
        end
        check("redirect_timeout", {31'd0, redirect_valid}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_exc_valid"}, {31'd0, exc_valid}, 32'd0);
        check({tag, "_excode"}, {27'd0, exc_excode}, 32'd0);
        check({tag, "_bd"}, {31'd0, exc_bd}, 32'd0);
        check({tag, "_eret"}, {31'd0, exc_eret}, 32'd0);
        check({tag, "_epc"}, exc_epc, 32'd0);
        check({tag, "_badvaddr"}, exc_badvaddr, 32'd0);
        check({tag, "_flush"}, {31'd0, flush}, 32'd0);
        check({tag, "_redirect_valid"}, {31'd0, redirect_valid}, 32'd0);
        check({tag, "_redirect_pc"}, redirect_pc, 32'd0);
    endtask

    always @(negedge clk) begin
        if (exc_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_event: got exc_valid=1 excode=%0d expected no event", exc_excode);
            end else begin
                mon_e = sb.pop_front();
                $display("[TB] event excode=%0d bd=%0b eret=%0b epc=%h badvaddr=%h redirect_pc=%h",
                         exc_excode, exc_bd, exc_eret, exc_epc, exc_badvaddr, redirect_pc);
                check("ev_excode", {27'd0, exc_excode}, {27'd0, mon_e.code});
                check("ev_bd", {31'd0, exc_bd}, {31'd0, mon_e.bd});
                check("ev_eret", {31'd0, exc_eret}, {31'd0, mon_e.eret});
                check("ev_epc", exc_epc, mon_e.epc);
                check("ev_badvaddr", exc_badvaddr, mon_e.bad);
                check("ev_redirect_pc", redirect_pc, mon_e.rpc);
                check("ev_flush", {31'd0, flush}, 32'd1);
                check("ev_redirect_valid", {31'd0, redirect_valid}, 32'd1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 0; redirect_ready = 1; bev = 0; cp0_epc = 0; m_pc = 0; m_addr = 0;
        clear_m();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");

        // First cycle out of reset captures an overflow
        resetn = 1;
        issue(32'hBFC0_0100, 32'h0, 0, F_OV, 1, 32'h0, 5'd12, 0, 0, 32'hBFC0_0100, 32'h0, 32'hBFC0_0380);
        @(negedge clk);
        check("flush_first_cycle", {31'd0, flush}, 32'd1);
        @(negedge clk);
        check("flush_one_cycle", {31'd0, flush}, 32'd0);
        check("exc_valid_strobe", {31'd0, exc_valid}, 32'd0);
        check("excode_hold", {27'd0, exc_excode}, 32'd12);

        issue(32'h8000_0008, 32'h0000_1001, 1, F_LD, 0, 32'h0, 5'd4, 1, 0, 32'h8000_0004, 32'h0000_1001, 32'h8000_0180);
        wait_idle();
        issue(32'h8000_0010, 32'h0000_0055, 0, F_IFADEL | F_RI, 0, 32'h0, 5'd4, 0, 0, 32'h8000_0010, 32'h8000_0010, 32'h8000_0180);
        wait_idle();
        issue(32'h8000_0020, 32'h0000_2002, 0, F_ST, 0, 32'h0, 5'd5, 0, 0, 32'h8000_0020, 32'h0000_2002, 32'h8000_0180);
        wait_idle();
        issue(32'h8000_0024, 32'h0000_3000, 0, F_BP | F_OV | F_ST, 0, 32'h0, 5'd9, 0, 0, 32'h8000_0024, 32'h0, 32'h8000_0180);
        wait_idle();
        issue(32'h0000_0000, 32'h0, 1, F_SYS, 1, 32'h0, 5'd8, 1, 0, 32'hFFFF_FFFC, 32'h0, 32'hBFC0_0380);
        wait_idle();
        issue(32'h8000_0040, 32'h0, 0, F_INT | F_ERET | F_RI, 0, 32'h8000_1234, 5'd0, 0, 0, 32'h8000_0040, 32'h0, 32'h8000_0180);
        wait_idle();
        issue(32'h8000_0044, 32'h0, 0, F_ERET, 0, 32'h8000_1234, 5'd0, 0, 1, 32'h8000_0044, 32'h0, 32'h8000_1234);
        wait_idle();

        // Held redirect with a syscall presented during REDIRECT
        redirect_ready = 0;
        issue(32'h8000_0100, 32'h0, 0, F_SYS, 0, 32'h0, 5'd8, 0, 0, 32'h8000_0100, 32'h0, 32'h8000_0180);
        m_valid = 1; m_sys = 1; m_pc = 32'h8000_0104;
        fcnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (flush) fcnt++;
            if (i == 2) check("redirect_pc_stable", redirect_pc, 32'h8000_0180);
            if (i == 3) begin
                redirect_ready = 1;
                clear_m();
            end
        end
        check("flush_cycles", fcnt, 32'd4);

        // Interrupt pending while no instruction can commit
        int_req = 1; m_valid = 0; m_pc = 32'h8000_0200;
        repeat (2) begin
            @(negedge clk);
            check("int_blocked_invalid", {31'd0, exc_valid}, 32'd0);
        end
        m_valid = 1; m_stall = 1;
        @(negedge clk);
        @(negedge clk);
        check("int_blocked_stall", {31'd0, exc_valid}, 32'd0);
        issue(32'h8000_0200, 32'h0, 0, F_INT, 0, 32'h0, 5'd0, 0, 0, 32'h8000_0200, 32'h0, 32'h8000_0180);
        @(negedge clk);
        check("int_latency", {31'd0, exc_valid}, 32'd1);
        wait_idle();

        // Reset in the middle of REDIRECT
        redirect_ready = 0;
        issue(32'h8000_0300, 32'h0, 0, F_SYS, 1, 32'h0, 5'd8, 0, 0, 32'h8000_0300, 32'h0, 32'hBFC0_0380);
        @(negedge clk);
        resetn = 0;
        @(negedge clk);
        check_all_zero("mid_reset");
        resetn = 1; redirect_ready = 1;
        @(negedge clk);
        check("post_reset_idle", {31'd0, flush}, 32'd0);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 SHALL have parameter VEC_BEV, default 32'hBFC0_0380, exception vector when bev=1.
REQ-002 SHALL have parameter VEC_NORM, default 32'h8000_0180, exception vector when bev=0.
REQ-003 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-004 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports m_valid, m_stall  in  1 each  commit-stage instruction valid / commit-stage stalled.
REQ-006 SHALL have ports m_pc, m_addr  in  32 each  commit PC / data-access address.
REQ-007 SHALL have ports m_bd, m_if_adel, m_ri, m_sys, m_bp, m_ov, m_ld_adel, m_st_ades, m_eret  in  1 each  delay-slot flag, per-cause exception flags, eret flag.
REQ-008 SHALL have ports int_req, bev  in  1 each  interrupt-response level from CP0 / Status.BEV.
REQ-009 SHALL have port cp0_epc  in  32  current EPC from CP0.
REQ-010 SHALL have ports exc_valid, exc_bd, exc_eret  out  1 each  one-cycle event strobe to CP0 and its qualifiers.
REQ-011 SHALL have port exc_excode  out  5  exception code.
REQ-012 SHALL have ports exc_epc, exc_badvaddr  out  32 each  EPC and BadVAddr to CP0.
REQ-013 SHALL have port flush  out  1  pipeline flush.
REQ-014 SHALL have ports redirect_valid  out  1, redirect_pc  out  32, redirect_ready  in  1  fetch redirect handshake.

Function
REQ-015 SHALL implement FSM states IDLE, REDIRECT.
REQ-016 In IDLE, capture SHALL occur on a cycle with m_valid=1, m_stall=0, and (int_req or any exception flag or m_eret).
REQ-017 Cause priority SHALL be: int_req (Int, 0) > m_if_adel (AdEL, 4) > m_ri (RI, 10) > m_sys (Sys, 8) > m_bp (Bp, 9) > m_ov (Ov, 12) > m_ld_adel (AdEL, 4) > m_st_ades (AdES, 5) > m_eret.
REQ-018 On capture, next cycle: exc_valid=1 for exactly one cycle, exc_excode per REQ-017, exc_bd=m_bd, exc_eret=1 only if m_eret was the winning cause (exc_excode then 0).
REQ-019 exc_epc SHALL be m_pc-4 (mod 2^32) when m_bd=1, else m_pc.
REQ-020 exc_badvaddr SHALL be m_pc if m_if_adel won, m_addr if m_ld_adel/m_st_ades won, else 0.
REQ-021 redirect_pc SHALL be cp0_epc sampled at capture for eret; else VEC_BEV if bev=1, VEC_NORM if bev=0, sampled at capture.
REQ-022 Cycle after capture: FSM->REDIRECT, redirect_valid=1, flush=1.
REQ-023 In REDIRECT: flush and redirect_valid held 1, redirect_pc stable; all m_* and int_req ignored.
REQ-024 REDIRECT->IDLE on cycle where redirect_valid=1 and redirect_ready=1; flush, redirect_valid 0 next cycle.
REQ-025 redirect_ready=1 in the first REDIRECT cycle SHALL complete in 1 cycle (minimum 1 flush cycle per event).
REQ-026 m_stall=1 or m_valid=0 SHALL block capture; int_req remains level-sensitive and is taken on next eligible instruction.
REQ-027 exc_* outputs other than exc_valid SHALL hold last captured value; exc_valid=0 outside the capture+1 cycle.

Reset
REQ-028 resetn=0 SHALL force IDLE, exc_valid=0, exc_excode=0, exc_bd=0, exc_eret=0, exc_epc=0, exc_badvaddr=0, flush=0, redirect_valid=0, redirect_pc=0, including mid-REDIRECT.
REQ-029 First capture SHALL be possible on the first cycle with resetn=1.

Verification
REQ-030 m_valid=1, m_pc=0xBFC0_0100, m_ov=1, bev=1 -> next cycle exc_valid=1, excode=12, epc=0xBFC0_0100, redirect_pc=0xBFC0_0380, flush=1.
REQ-031 m_bd=1, m_pc=0x8000_0008, m_ld_adel=1, m_addr=0x1001, bev=0 -> excode=4, epc=0x8000_0004, badvaddr=0x1001, exc_bd=1, redirect_pc=0x8000_0180.
REQ-032 int_req=1 with m_eret=1, m_ri=1 same instruction -> excode=0, exc_eret=0; then m_eret alone, cp0_epc=0x8000_1234 -> exc_eret=1, redirect_pc=0x8000_1234.
REQ-033 redirect_ready=0 for 3 cycles then 1 -> flush/redirect_valid high 4 cycles, second m_sys during REDIRECT produces no exc_valid.
REQ-034 int_req=1 with m_valid=0 for 2 cycles, then m_valid=1 -> single exc_valid, excode=0, one cycle after m_valid rises.
REQ-035 resetn=0 during REDIRECT -> next cycle flush=0, redirect_valid=0, all outputs 0, FSM IDLE.
